i2c_master: RTL and testbench

I2C bus initiator that performs single-register write and read transactions against 7-bit-addressed peripherals, such as the team's I2C slave memory/GPIO block at address 0x70. It sits between on-chip control logic and the open-drain SCL/SDA pads on the bidirectional IO bank. Control logic gives it one command at a time. The master generates START, address, register-pointer, data, ACK/NACK, repeated-START and STOP framing, and reports the outcome.

---
 rtl/i2c_master.sv | 309 ++++++++++++++++++++++++++++++
 tb/tb_i2c_master.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_master.sv
// i2c_master: single-register I2C write/read initiator for 7-bit addressed
// peripherals. One command at a time. Each command produces a complete frame:
// START, address, register pointer, then either the data byte or a repeated
// START plus a one-byte read, then STOP. SCL and SDA are driven open-drain
// through the *_oe outputs.
module i2c_master #(
  parameter int CLKDIV = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       rw,
  input  logic [6:0] dev_addr,
  input  logic [7:0] reg_addr,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic       nack,
  output logic [7:0] rdata,
  input  logic       scl_i,
  output logic       scl_oe,
  input  logic       sda_i,
  output logic       sda_oe
);

  localparam int PW = (CLKDIV > 2) ? $clog2(CLKDIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLKDIV - 1);
  localparam logic [PW-1:0] PRESC_ZERO = {PW{1'b0}};
  localparam logic [PW-1:0] PRESC_ONE  = PW'(1'b1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_TX     = 3'd2,
    S_ACK    = 3'd3,
    S_RSTART = 3'd4,
    S_RX     = 3'd5,
    S_MNACK  = 3'd6,
    S_STOP   = 3'd7
  } state_t;

  // Byte sent on the wire for each value of the byte counter:
  // 0 = address+W, 1 = register pointer, 2 = write data, 3 = address+R.
  function automatic logic [7:0] tx_byte_f(input logic [1:0] sel,
                                           input logic [6:0] dev,
                                           input logic [7:0] ra,
                                           input logic [7:0] wd);
    logic [7:0] b;
    case (sel)
      2'd0:    b = {dev, 1'b0};
      2'd1:    b = ra;
      2'd2:    b = wd;
      2'd3:    b = {dev, 1'b1};
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  // Line drive for a given state and quarter, returned as {scl_oe, sda_oe}.
  // SDA only moves while SCL is held low, except in START/RSTART/STOP, where
  // the SDA edge during high SCL is the bus condition being generated.
  function automatic logic [1:0] lines_f(input state_t st,
                                         input logic [1:0] q,
                                         input logic bit_v);
    logic [1:0] l;
    l = 2'b00;
    case (st)
      S_IDLE:  l = 2'b00;
      S_START: l = q[1] ? 2'b01 : 2'b00;
      S_TX:    l = {~q[1], ~bit_v};
      S_ACK,
      S_RX,
      S_MNACK: l = {~q[1], 1'b0};
      S_RSTART: begin
        case (q)
          2'd0, 2'd1: l = 2'b10;
          2'd2:       l = 2'b00;
          2'd3:       l = 2'b01;
          default:    l = 2'b00;
        endcase
      end
      S_STOP: begin
        case (q)
          2'd0, 2'd1: l = 2'b11;
          2'd2:       l = 2'b01;
          2'd3:       l = 2'b00;
          default:    l = 2'b00;
        endcase
      end
      default: l = 2'b00;
    endcase
    return l;
  endfunction

  state_t          state_r, state_nx_s;
  logic [PW-1:0]   presc_r, presc_nx_s;
  logic [1:0]      q_r, q_nx_s;
  logic [2:0]      bit_cnt_r, bit_cnt_nx_s;
  logic [1:0]      byte_cnt_r, byte_cnt_nx_s;
  logic            rw_r;
  logic [6:0]      dev_r;
  logic [7:0]      reg_r;
  logic [7:0]      wdata_r;
  logic [7:0]      rx_sh_r;
  logic            nack_seen_r;
  logic            done_nx_s;
  logic            accept_s;
  logic            stretch_s;
  logic            tick_s;
  logic            end_q2_s;
  logic            end_q3_s;
  logic [7:0]      tx_nx_byte_s;
  logic [1:0]      lines_nx_s;

  // Command acceptance, clock-stretch freeze and quarter-tick qualification.
  always_comb begin
    accept_s  = (state_r == S_IDLE) && !busy && start;
    stretch_s = (state_r != S_IDLE) && (q_r == 2'd2) && !scl_i;
    tick_s    = (state_r != S_IDLE) && !stretch_s && (presc_r == PRESC_LAST);
    end_q2_s  = tick_s && (q_r == 2'd2);
    end_q3_s  = tick_s && (q_r == 2'd3);
  end

  // Prescaler and quarter counter: prescaler parked at zero while idle.
  always_comb begin
    presc_nx_s = presc_r;
    q_nx_s     = q_r;
    if (state_r == S_IDLE) begin
      presc_nx_s = PRESC_ZERO;
    end else if (stretch_s) begin
      presc_nx_s = presc_r;
    end else if (tick_s) begin
      presc_nx_s = PRESC_ZERO;
    end else begin
      presc_nx_s = presc_r + PRESC_ONE;
    end
    if (state_r == S_IDLE) begin
      q_nx_s = 2'd0;
    end else if (tick_s) begin
      q_nx_s = q_r + 2'd1;
    end else begin
      q_nx_s = q_r;
    end
  end

  // Frame sequencing: state, bit and byte counters advance at the end of Q3.
  always_comb begin
    state_nx_s    = state_r;
    bit_cnt_nx_s  = bit_cnt_r;
    byte_cnt_nx_s = byte_cnt_r;
    done_nx_s     = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (accept_s) begin
          state_nx_s    = S_START;
          bit_cnt_nx_s  = 3'd7;
          byte_cnt_nx_s = 2'd0;
        end else begin
          state_nx_s = S_IDLE;
        end
      end
      S_START: begin
        if (end_q3_s) begin
          state_nx_s   = S_TX;
          bit_cnt_nx_s = 3'd7;
        end else begin
          state_nx_s = S_START;
        end
      end
      S_TX: begin
        if (end_q3_s && (bit_cnt_r == 3'd0)) begin
          state_nx_s = S_ACK;
        end else if (end_q3_s) begin
          bit_cnt_nx_s = bit_cnt_r - 3'd1;
        end else begin
          state_nx_s = S_TX;
        end
      end
      S_ACK: begin
        if (end_q3_s && nack_seen_r) begin
          state_nx_s = S_STOP;
        end else if (end_q3_s) begin
          bit_cnt_nx_s = 3'd7;
          case (byte_cnt_r)
            2'd0: begin
              state_nx_s    = S_TX;
              byte_cnt_nx_s = 2'd1;
            end
            2'd1: begin
              state_nx_s    = rw_r ? S_RSTART : S_TX;
              byte_cnt_nx_s = rw_r ? 2'd3 : 2'd2;
            end
            2'd2:    state_nx_s = S_STOP;
            2'd3:    state_nx_s = S_RX;
            default: state_nx_s = S_STOP;
          endcase
        end else begin
          state_nx_s = S_ACK;
        end
      end
      S_RSTART: begin
        if (end_q3_s) begin
          state_nx_s   = S_TX;
          bit_cnt_nx_s = 3'd7;
        end else begin
          state_nx_s = S_RSTART;
        end
      end
      S_RX: begin
        if (end_q3_s && (bit_cnt_r == 3'd0)) begin
          state_nx_s = S_MNACK;
        end else if (end_q3_s) begin
          bit_cnt_nx_s = bit_cnt_r - 3'd1;
        end else begin
          state_nx_s = S_RX;
        end
      end
      S_MNACK: begin
        if (end_q3_s) begin
          state_nx_s = S_STOP;
        end else begin
          state_nx_s = S_MNACK;
        end
      end
      S_STOP: begin
        if (end_q3_s) begin
          state_nx_s = S_IDLE;
          done_nx_s  = 1'b1;
        end else begin
          state_nx_s = S_STOP;
        end
      end
      default: begin
        state_nx_s = S_IDLE;
      end
    endcase
  end

  // Pad drive for the upcoming quarter, decoded from next-state values so the
  // registered outputs switch exactly on quarter boundaries.
  always_comb begin
    tx_nx_byte_s = tx_byte_f(byte_cnt_nx_s, dev_r, reg_r, wdata_r);
    lines_nx_s   = lines_f(state_nx_s, q_nx_s, tx_nx_byte_s[bit_cnt_nx_s]);
  end

  // Sequencer state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= S_IDLE;
      presc_r    <= PRESC_ZERO;
      q_r        <= 2'd0;
      bit_cnt_r  <= 3'd0;
      byte_cnt_r <= 2'd0;
    end else begin
      state_r    <= state_nx_s;
      presc_r    <= presc_nx_s;
      q_r        <= q_nx_s;
      bit_cnt_r  <= bit_cnt_nx_s;
      byte_cnt_r <= byte_cnt_nx_s;
    end
  end

  // Command capture, bus sampling and registered status/pad outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      rw_r        <= 1'b0;
      dev_r       <= 7'h00;
      reg_r       <= 8'h00;
      wdata_r     <= 8'h00;
      rx_sh_r     <= 8'h00;
      nack_seen_r <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      nack        <= 1'b0;
      rdata       <= 8'h00;
      scl_oe      <= 1'b0;
      sda_oe      <= 1'b0;
    end else begin
      scl_oe <= lines_nx_s[1];
      sda_oe <= lines_nx_s[0];
      done   <= done_nx_s;
      if (accept_s) begin
        busy <= 1'b1;
      end else if (done) begin
        busy <= 1'b0;
      end
      if (accept_s) begin
        rw_r        <= rw;
        dev_r       <= dev_addr;
        reg_r       <= reg_addr;
        wdata_r     <= wdata;
        nack        <= 1'b0;
        nack_seen_r <= 1'b0;
      end else if ((state_r == S_ACK) && end_q2_s && sda_i) begin
        nack_seen_r <= 1'b1;
      end
      if ((state_r == S_RX) && end_q2_s) begin
        rx_sh_r <= {rx_sh_r[6:0], sda_i};
      end
      if (done_nx_s) begin
        nack <= nack_seen_r;
        if (rw_r && !nack_seen_r) begin
          rdata <= rx_sh_r;
        end
      end
    end
  end

endmodule

// File: tb/tb_i2c_master.sv
// tb_i2c_master: directed bench for i2c_master with a behavioural I2C target
// (address 0x70) that ACKs, returns a read byte and can stretch SCL once.
module tb_i2c_master;

  localparam int D = 4;
  localparam logic [6:0] MODEL_ADDR = 7'h70;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       rw = 1'b0;
  logic [6:0] dev_addr = 7'h00;
  logic [7:0] reg_addr = 8'h00;
  logic [7:0] wdata = 8'h00;
  logic       busy, done, nack;
  logic [7:0] rdata;
  logic       scl_oe, sda_oe;
  logic       scl_pad, sda_pad;

  // target model state
  logic       hold = 1'b0;
  int         hcnt = 0;
  logic       sda_low = 1'b0;
  logic       scl_p = 1'b1, sda_p = 1'b1;
  int         bcnt = 0, byte_no = 0;
  logic [7:0] shreg = 8'h00;
  logic       match = 1'b0, rd_flag = 1'b0, sending = 1'b0, data_done = 1'b0;
  logic [7:0] rx_log [0:7];
  int         nlog = 0, nstart = 0, nstop = 0;
  logic       mnack_val = 1'b0, mnack_seen = 1'b0;
  logic       clr_tog = 1'b0, clr_seen = 1'b0;
  logic       stretch_en = 1'b0;
  logic [7:0] rd_byte = 8'h00;

  int passed = 0, total = 0, fails = 0;
  int cyc;
  logic saw_done;

  assign scl_pad = !(scl_oe || hold);
  assign sda_pad = !(sda_oe || sda_low);

  i2c_master #(.CLKDIV(D)) dut (
    .clk(clk), .rst(rst), .start(start), .rw(rw), .dev_addr(dev_addr),
    .reg_addr(reg_addr), .wdata(wdata), .busy(busy), .done(done),
    .nack(nack), .rdata(rdata), .scl_i(scl_pad), .scl_oe(scl_oe),
    .sda_i(sda_pad), .sda_oe(sda_oe)
  );

  always #5 clk = ~clk;

  // Behavioural I2C target: decodes START/STOP, shifts bytes, ACKs its address.
  always @(posedge clk) begin
    if (clr_tog != clr_seen) begin
      clr_seen   <= clr_tog;
      nlog       <= 0;
      nstart     <= 0;
      nstop      <= 0;
      mnack_val  <= 1'b0;
      mnack_seen <= 1'b0;
    end else if (scl_p && scl_pad && sda_p && !sda_pad) begin
      nstart    <= nstart + 1;
      bcnt      <= 0;
      byte_no   <= 0;
      sending   <= 1'b0;
      data_done <= 1'b0;
      sda_low   <= 1'b0;
    end else if (scl_p && scl_pad && !sda_p && sda_pad) begin
      nstop <= nstop + 1;
    end else if (!scl_p && scl_pad) begin
      if (bcnt < 8) shreg <= {shreg[6:0], sda_pad};
      if (bcnt == 8 && sending) begin
        mnack_val  <= sda_pad;
        mnack_seen <= 1'b1;
        data_done  <= 1'b1;
        sending    <= 1'b0;
      end
      bcnt <= bcnt + 1;
    end else if (scl_p && !scl_pad) begin
      if (bcnt == 8) begin
        if (sending) begin
          sda_low <= 1'b0;
        end else begin
          if (nlog < 8) rx_log[nlog] <= shreg;
          nlog <= nlog + 1;
          if (byte_no == 0) begin
            match   <= (shreg[7:1] == MODEL_ADDR);
            rd_flag <= shreg[0];
            sda_low <= (shreg[7:1] == MODEL_ADDR);
          end else begin
            sda_low <= match;
          end
        end
      end else if (bcnt == 9) begin
        bcnt    <= 0;
        byte_no <= byte_no + 1;
        if (match && rd_flag && !data_done) begin
          sending <= 1'b1;
          sda_low <= !rd_byte[7];
        end else begin
          sda_low <= 1'b0;
        end
      end else if (sending && bcnt >= 1 && bcnt <= 7) begin
        sda_low <= !rd_byte[7-bcnt];
      end
      if (stretch_en && byte_no == 1 && bcnt == 4) hold <= 1'b1;
    end
    if (hold && !scl_oe) begin
      if (hcnt == 36) begin
        hold <= 1'b0;
        hcnt <= 0;
      end else begin
        hcnt <= hcnt + 1;
      end
    end
    scl_p <= scl_pad;
    sda_p <= sda_pad;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one command at the current negedge; returns clocks from busy rise to done.
  task automatic run_cmd(input logic r, input logic [6:0] d, input logic [7:0] ra,
                         input logic [7:0] wd, input int poke, output int n);
    clr_tog  = ~clr_tog;
    start    = 1'b1;
    rw       = r;
    dev_addr = d;
    reg_addr = ra;
    wdata    = wd;
    @(negedge clk);
    start = 1'b0;
    chk("busy_rise", busy, 1);
    n = 0;
    while (done !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
      if (n == poke) begin
        start    = 1'b1;
        rw       = ~r;
        dev_addr = 7'h21;
        reg_addr = 8'hFF;
        wdata    = 8'h00;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    chk("done_pulse", done, 1);
    @(negedge clk);
    chk("done_drop", done, 0);
    chk("busy_drop", busy, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_scl_oe", scl_oe, 0);
    chk("rst_sda_oe", sda_oe, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_nack", nack, 0);
    chk("rst_rdata", rdata, 8'h00);

    // register write with ACKing target
    run_cmd(1'b0, 7'h70, 8'h02, 8'h5A, -1, cyc);
    chk("wr_cycles", cyc, 116 * D);
    chk("wr_nack", nack, 0);
    chk("wr_nlog", nlog, 3);
    chk("wr_b0", rx_log[0], 8'hE0);
    chk("wr_b1", rx_log[1], 8'h02);
    chk("wr_b2", rx_log[2], 8'h5A);
    chk("wr_nstart", nstart, 1);
    chk("wr_nstop", nstop, 1);
    chk("wr_idle_scl", scl_oe, 0);
    chk("wr_idle_sda", sda_oe, 0);

    // register read, target returns 0xA5
    rd_byte = 8'hA5;
    run_cmd(1'b1, 7'h70, 8'h04, 8'h00, -1, cyc);
    chk("rd_cycles", cyc, 156 * D);
    chk("rd_rdata", rdata, 8'hA5);
    chk("rd_nack", nack, 0);
    chk("rd_nlog", nlog, 3);
    chk("rd_b0", rx_log[0], 8'hE0);
    chk("rd_b1", rx_log[1], 8'h04);
    chk("rd_b2", rx_log[2], 8'hE1);
    chk("rd_nstart", nstart, 2);
    chk("rd_mnack_seen", mnack_seen, 1);
    chk("rd_mnack_val", mnack_val, 1);
    chk("rd_nstop", nstop, 1);

    // absent device: address NACK, then STOP only
    run_cmd(1'b0, 7'h21, 8'h33, 8'h44, -1, cyc);
    chk("nd_cycles", cyc, 44 * D);
    chk("nd_nack", nack, 1);
    chk("nd_rdata", rdata, 8'hA5);
    chk("nd_nlog", nlog, 1);
    chk("nd_b0", rx_log[0], 8'h42);
    chk("nd_nstop", nstop, 1);
    @(negedge clk);
    chk("nd_nack_hold", nack, 1);

    // SCL stretched 37 clocks during reg_addr bit 3
    stretch_en = 1'b1;
    run_cmd(1'b0, 7'h70, 8'h3C, 8'h81, -1, cyc);
    stretch_en = 1'b0;
    chk("st_cycles", cyc, 116 * D + 37);
    chk("st_nack", nack, 0);
    chk("st_b0", rx_log[0], 8'hE0);
    chk("st_b1", rx_log[1], 8'h3C);
    chk("st_b2", rx_log[2], 8'h81);

    // start pulsed while busy is ignored
    run_cmd(1'b0, 7'h70, 8'h11, 8'hC3, 40, cyc);
    chk("ig_cycles", cyc, 116 * D);
    chk("ig_nlog", nlog, 3);
    chk("ig_b0", rx_log[0], 8'hE0);
    chk("ig_b1", rx_log[1], 8'h11);
    chk("ig_b2", rx_log[2], 8'hC3);
    chk("ig_nstart", nstart, 1);

    // back-to-back: start in the cycle after done
    rd_byte = 8'h3C;
    run_cmd(1'b1, 7'h70, 8'h22, 8'h00, -1, cyc);
    chk("bb_cycles", cyc, 156 * D);
    chk("bb_rdata", rdata, 8'h3C);
    chk("bb_b1", rx_log[1], 8'h22);

    // reset during wdata bit 4 (wdata 0xA5: bit 4 is 0, so SDA pulled low)
    clr_tog  = ~clr_tog;
    start    = 1'b1;
    rw       = 1'b0;
    dev_addr = 7'h70;
    reg_addr = 8'h55;
    wdata    = 8'hA5;
    @(negedge clk);
    start = 1'b0;
    repeat (358) @(negedge clk);
    chk("mr_pre_scl", scl_oe, 1);
    chk("mr_pre_sda", sda_oe, 1);
    chk("mr_pre_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("mr_scl_oe", scl_oe, 0);
    chk("mr_sda_oe", sda_oe, 0);
    chk("mr_busy", busy, 0);
    chk("mr_done", done, 0);
    rst = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done === 1'b1) saw_done = 1'b1;
    end
    chk("mr_no_done", saw_done, 0);
    chk("mr_rdata", rdata, 8'h00);
    chk("mr_nack", nack, 0);

    // recovery after abandoned frame
    run_cmd(1'b0, 7'h70, 8'h02, 8'h5A, -1, cyc);
    chk("rc_cycles", cyc, 116 * D);
    chk("rc_b2", rx_log[2], 8'h5A);
    chk("rc_nack", nack, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
